ifetch_unit: RTL

- Instruction fetch stage for the extended single-cycle MIPS core.
- Holds the PC, issues word reads to instruction memory over a req/ready handshake, and captures the returned word in an instruction register.
- Presents `instr`/`op` to the main decoder and datapath, then advances the PC on downstream acknowledge: PC+4, branch target (BEQ/BLT taken, supplied by datapath) or jump target (computed locally).

---
 rtl/mips_pkg.sv | 19 +
 rtl/next_pc.sv | 30 +++
 rtl/ifetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS instruction fetch stage.
//   fetch_state_t : fetch FSM state encoding (IDLE, REQ, HOLD)
//   OP_J          : opcode of the J (jump) instruction
//   OP_MSB/OP_LSB : opcode field position inside an instruction word
//   JIDX_W        : width of the jump index field instr[25:0]
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam int         OP_MSB = 31;
  localparam int         OP_LSB = 26;
  localparam int         JIDX_W = 26;

endpackage

// File: rtl/next_pc.sv
// next_pc: combinational next-PC selection for the fetch stage.
// Ports:
//   pcplus4       in  32  address of the following sequential instruction
//   instr         in  32  instruction currently being retired
//   take_branch   in  1   taken BEQ/BLT indication from the datapath
//   branch_target in  32  branch destination from the datapath
//   npc           out 32  selected next PC
// Priority: jump (decoded here) > taken branch > sequential.
module next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pcplus4,
  input  logic [31:0] instr,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  output logic [31:0] npc
);

  always_comb begin
    npc = pcplus4;
    if (instr[OP_MSB:OP_LSB] == OP_J) begin
      // Jump stays within the 256 MB region of the delay-free successor.
      npc = {pcplus4[31:28], instr[JIDX_W-1:0], 2'b00};
    end else if (take_branch) begin
      // Force word alignment regardless of what the datapath supplies.
      npc = branch_target & ~32'h0000_0003;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage of the single-cycle MIPS core.
// Holds the PC, reads instruction memory over a req/ready handshake, keeps
// the returned word in an instruction register until downstream acknowledges
// it, then advances the PC (sequential, branch or jump) and counts retirement.
// Ports:
//   clk            in  1   core clock, rising edge
//   reset          in  1   asynchronous active-high reset
//   imem_req       out 1   instruction memory read request
//   imem_addr      out 32  read address (equals pc)
//   imem_ready     in  1   memory response valid, completes the request
//   imem_rdata     in  32  instruction word from memory
//   instr          out 32  captured instruction
//   op             out 6   opcode field of instr
//   instr_valid    out 1   instr holds an unconsumed instruction
//   instr_ack      in  1   downstream executed instr
//   take_branch    in  1   branch taken, sampled with instr_ack
//   branch_target  in  32  branch destination from datapath
//   pc             out 32  address of current instruction
//   pcplus4        out 32  pc + 4
//   retired        out 32  acknowledged instruction count (wraps)
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] retired
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_retired;
  logic         r_req;
  logic         r_valid;
  logic [31:0]  w_pcplus4;
  logic [31:0]  w_npc;

  assign w_pcplus4 = r_pc + 32'd4;

  next_pc u_next_pc (
    .pcplus4       (w_pcplus4),
    .instr         (r_instr),
    .take_branch   (take_branch),
    .branch_target (branch_target),
    .npc           (w_npc)
  );

  // FSM with registered request/valid outputs; r_req/r_valid mirror
  // (state == REQ)/(state == HOLD) so no input reaches an output directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_retired <= 32'd0;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= REQ;
          r_req   <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_state <= HOLD;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ack) begin
            r_pc      <= w_npc;
            r_retired <= r_retired + 32'd1;
            r_state   <= REQ;
            r_req     <= 1'b1;
            r_valid   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign op          = r_instr[OP_MSB:OP_LSB];
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign pcplus4     = w_pcplus4;
  assign retired     = r_retired;

endmodule
